awg_param_ctrl: RTL and testbench

//  Command decoder/shadow-register bank upstream of the square-wave generator.

---
 rtl/awg_pkg.sv | 40 ++++
 rtl/awg_gap_timer.sv | 30 +++
 rtl/awg_param_ctrl.sv | 129 ++++++++++++
 tb/tb_awg_param_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/awg_pkg.sv
// Shared definitions for the AWG command link: frame bytes, command codes, FSM encoding.
// Also used by host-side benches, so keep it free of implementation detail.
package awg_pkg;

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [7:0] CMD_FREQ   = 8'h01;
  localparam logic [7:0] CMD_AMP    = 8'h02;
  localparam logic [7:0] CMD_PHASE  = 8'h03;
  localparam logic [7:0] CMD_EN     = 8'h04;
  localparam logic [7:0] CMD_COMMIT = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_OK,
    ST_GOT_CMD,
    ST_GOT_DHI,
    ST_GOT_DLO,
    ST_EXEC,
    ST_RESP
  } state_t;

  // Range rule per command; amp may never be 0 since the generator divides by it.
  function automatic logic cmd_legal(input logic [7:0] cmd, input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_FREQ:   ok = (d[15:12] == 4'd0);
      CMD_AMP:    ok = (d >= 16'd1) && (d <= 16'd7);
      CMD_PHASE:  ok = (d[15:8] == 8'd0);
      CMD_EN:     ok = (d[15:1] == 15'd0);
      CMD_COMMIT: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/awg_gap_timer.sv
// Inter-byte gap timer: reloads on clear, counts down while enabled,
// and flags expiry on the last allowed cycle of the gap.
module awg_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/awg_param_ctrl.sv
// Frame decoder and shadow/live parameter bank for the square-wave generator.
// state      | meaning
// IDLE       | hunting for header, other bytes dropped
// HDR_OK     | header seen, waiting for CMD
// GOT_CMD    | waiting for DHI
// GOT_DHI    | waiting for DLO
// GOT_DLO    | waiting for CSUM
// EXEC       | validate frame, update regs, latch response
// RESP       | presenting ACK/NAK until taken
module awg_param_ctrl
  import awg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [11:0] FREQ_RST    = 12'd64,
  parameter logic [2:0]  AMP_RST     = 3'd1,
  parameter logic [7:0]  PHASE_RST   = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        en,
  output logic [11:0] freq,
  output logic [2:0]  amp,
  output logic [7:0]  phase,
  output logic        update
);

  state_t state, state_n;

  logic [7:0]  cmd_q, dhi_q, dlo_q, csum_q;
  logic        shadow_en;
  logic [11:0] shadow_freq;
  logic [2:0]  shadow_amp;
  logic [7:0]  shadow_phase;

  logic        acc, in_frame, expired, frame_ok;
  logic [15:0] d;

  assign rx_ready = (state != ST_EXEC) && (state != ST_RESP);
  assign tx_valid = (state == ST_RESP);
  assign acc      = rx_valid && rx_ready;
  assign in_frame = (state == ST_HDR_OK) || (state == ST_GOT_CMD) ||
                    (state == ST_GOT_DHI) || (state == ST_GOT_DLO);
  assign d        = {dhi_q, dlo_q};
  assign frame_ok = (csum_q == (cmd_q ^ dhi_q ^ dlo_q)) && cmd_legal(cmd_q, d);

  awg_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc),
    .enable  (in_frame),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (acc && (rx_data == HDR)) state_n = ST_HDR_OK;
      ST_HDR_OK:  if (acc) state_n = ST_GOT_CMD; else if (expired) state_n = ST_IDLE;
      ST_GOT_CMD: if (acc) state_n = ST_GOT_DHI; else if (expired) state_n = ST_IDLE;
      ST_GOT_DHI: if (acc) state_n = ST_GOT_DLO; else if (expired) state_n = ST_IDLE;
      ST_GOT_DLO: if (acc) state_n = ST_EXEC;    else if (expired) state_n = ST_IDLE;
      ST_EXEC:    state_n = ST_RESP;
      ST_RESP:    if (tx_ready) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Registers only move in EXEC, so an aborted frame never touches shadow or live.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q        <= '0;
      dhi_q        <= '0;
      dlo_q        <= '0;
      csum_q       <= '0;
      tx_data      <= '0;
      update       <= 1'b0;
      en           <= 1'b0;
      freq         <= FREQ_RST;
      amp          <= AMP_RST;
      phase        <= PHASE_RST;
      shadow_en    <= 1'b0;
      shadow_freq  <= FREQ_RST;
      shadow_amp   <= AMP_RST;
      shadow_phase <= PHASE_RST;
    end else begin
      update <= 1'b0;
      if (acc) begin
        case (state)
          ST_HDR_OK:  cmd_q  <= rx_data;
          ST_GOT_CMD: dhi_q  <= rx_data;
          ST_GOT_DHI: dlo_q  <= rx_data;
          ST_GOT_DLO: csum_q <= rx_data;
          default: ;
        endcase
      end
      if (state == ST_EXEC) begin
        tx_data <= frame_ok ? ACK : NAK;
        if (frame_ok) begin
          case (cmd_q)
            CMD_FREQ:  shadow_freq  <= d[11:0];
            CMD_AMP:   shadow_amp   <= d[2:0];
            CMD_PHASE: shadow_phase <= d[7:0];
            CMD_EN:    shadow_en    <= d[0];
            CMD_COMMIT: begin
              en     <= shadow_en;
              freq   <= shadow_freq;
              amp    <= shadow_amp;
              phase  <= shadow_phase;
              update <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_awg_param_ctrl.sv
// Scoreboard bench for awg_param_ctrl: a command-level model predicts each ACK/NAK
// and the live parameter set; a monitor checks every response handshake.
module tb_awg_param_ctrl;
  import awg_pkg::*;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        en;
  logic [11:0] freq;
  logic [2:0]  amp;
  logic [7:0]  phase;
  logic        update;

  always #5 clk = ~clk;

  awg_param_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .en       (en),
    .freq     (freq),
    .amp      (amp),
    .phase    (phase),
    .update   (update)
  );

  typedef struct {
    logic [7:0]  resp;
    logic        commit;
    logic        m_en;
    logic [11:0] m_freq;
    logic [2:0]  m_amp;
    logic [7:0]  m_phase;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   upd_cycles = 0;
  int   commits = 0;
  bit   amp_bad = 1'b0;

  // Reference parameter bank
  logic        s_en, l_en;
  logic [11:0] s_freq, l_freq;
  logic [2:0]  s_amp, l_amp;
  logic [7:0]  s_phase, l_phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic bit legal(input logic [7:0] cmd, input int d);
    case (cmd)
      8'h01:   return d < 4096;
      8'h02:   return (d >= 1) && (d <= 7);
      8'h03:   return d < 256;
      8'h04:   return d < 2;
      8'h05:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    l_en = 1'b0; l_freq = 12'd64; l_amp = 3'd1; l_phase = 8'd0;
    s_en = l_en; s_freq = l_freq; s_amp = l_amp; s_phase = l_phase;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 2000) begin
        errors++; checks++;
        $display("FAIL rx_stall_timeout: rx_ready low for %0d cycles, byte 0x%0h", n, b);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench aborted");
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] d, input bit bad);
    exp_t e;
    logic [7:0] cs;
    cs = cmd ^ d[15:8] ^ d[7:0] ^ {7'd0, bad};
    e.commit = 1'b0;
    if (!bad && legal(cmd, int'(d))) begin
      case (cmd)
        8'h01: s_freq  = d[11:0];
        8'h02: s_amp   = d[2:0];
        8'h03: s_phase = d[7:0];
        8'h04: s_en    = d[0];
        default: begin
          l_en = s_en; l_freq = s_freq; l_amp = s_amp; l_phase = s_phase;
          e.commit = 1'b1;
          commits++;
        end
      endcase
      e.resp = 8'h06;
    end else begin
      e.resp = 8'h15;
    end
    e.m_en = l_en; e.m_freq = l_freq; e.m_amp = l_amp; e.m_phase = l_phase;
    q.push_back(e);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(cs);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    model_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_update",   32'(update),   32'd0);
    check("rst_live", 32'({en, freq, amp, phase}), 32'({1'b0, 12'd64, 3'd1, 8'd0}));
    rst = 1'b0;
  endtask

  // Response monitor
  initial begin : mon
    exp_t e;
    bit   fc;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (amp === 3'd0) amp_bad = 1'b1;
        if (update) begin
          upd_cycles++;
          fc = 1'b0;
          if (q.size() > 0) fc = q[0].commit;
          check("update_on_commit_resp", 32'({tx_valid, fc}), 32'd3);
        end
        if (tx_valid && tx_ready) begin
          if (q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_tx: got 0x%0h expected no response", tx_data);
          end else begin
            e = q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e.resp));
            check("live_at_resp", 32'({en, freq, amp, phase}),
                  32'({e.m_en, e.m_freq, e.m_amp, e.m_phase}));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++; checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench aborted");
  end

  initial begin : stim
    bit tv_seen, stable;
    logic [7:0] cap, g;
    logic [7:0] rc;
    logic [15:0] rd;
    int n;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Staging only; live holds reset values
    send_frame(CMD_FREQ,  16'h0123, 1'b0);
    send_frame(CMD_AMP,   16'h0004, 1'b0);
    send_frame(CMD_PHASE, 16'h0040, 1'b0);
    send_frame(CMD_EN,    16'h0001, 1'b0);
    drain();

    send_frame(CMD_COMMIT, 16'h0000, 1'b0);
    drain();
    check("commit_update_cycles", 32'(upd_cycles), 32'd1);
    check("commit_live", 32'({en, freq, amp, phase}), 32'({1'b1, 12'h123, 3'd4, 8'h40}));

    // Rejected frames leave everything alone
    send_frame(CMD_AMP,  16'h0000, 1'b0);
    send_frame(CMD_COMMIT, 16'h0000, 1'b0);
    send_frame(CMD_AMP,  16'h0008, 1'b0);
    send_frame(CMD_COMMIT, 16'h0000, 1'b0);
    send_frame(8'h07,    16'h0001, 1'b0);
    send_frame(CMD_COMMIT, 16'h0000, 1'b0);
    send_frame(CMD_FREQ, 16'h0321, 1'b1);
    send_frame(CMD_COMMIT, 16'h0000, 1'b0);
    drain();
    check("amp_after_naks", 32'(amp), 32'd4);

    // Garbage outside a frame, then a partial frame that times out
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'hFF);
    send_frame(CMD_FREQ, 16'h0456, 1'b0);
    drain();
    send_byte(8'hA5);
    send_byte(8'h01);
    tv_seen = 1'b0;
    repeat (TO) begin
      @(negedge clk);
      tv_seen |= tx_valid;
    end
    @(posedge clk); #1;
    check("timeout_no_resp", 32'(tv_seen), 32'd0);
    send_frame(CMD_PHASE, 16'h0011, 1'b0);
    drain();

    // Backpressure on the response while the next frame waits
    tx_ready = 1'b0;
    send_frame(CMD_EN, 16'h0000, 1'b0);
    fork
      send_frame(CMD_COMMIT, 16'h0000, 1'b0);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!tx_valid && n < 10);
        cap = tx_data;
        stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (!tx_valid || tx_data !== cap || rx_ready) stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_resp", 32'(cap), 32'h06);
        @(posedge clk); #1;
        tx_ready = 1'b1;
      end
    join
    drain();
    check("stall_live", 32'({en, freq, amp, phase}), 32'({1'b0, 12'h456, 3'd4, 8'h11}));

    // Randomized command mix
    for (int i = 0; i < 40; i++) begin
      rc = 8'($urandom_range(1, 7));
      case ($urandom_range(0, 2))
        0:       rd = 16'($urandom_range(0, 8));
        1:       rd = 16'($urandom_range(0, 300));
        default: rd = 16'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
      end
      send_frame(rc, rd, $urandom_range(0, 7) == 0);
    end
    drain();
    check("random_update_cycles", 32'(upd_cycles), 32'(commits));

    // Reset mid-frame: staged shadows are dropped too
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    do_reset();
    send_frame(CMD_COMMIT, 16'h0000, 1'b0);
    send_frame(CMD_AMP, 16'h0003, 1'b0);
    send_frame(CMD_COMMIT, 16'h0000, 1'b0);
    drain();

    // Reset while a response is pending
    tx_ready = 1'b0;
    send_frame(CMD_FREQ, 16'h0777, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    tx_ready = 1'b1;
    tv_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      tv_seen |= tx_valid;
    end
    @(posedge clk); #1;
    check("no_stale_ack", 32'(tv_seen), 32'd0);
    send_frame(CMD_COMMIT, 16'h0000, 1'b0);
    drain();
    check("final_update_cycles", 32'(upd_cycles), 32'(commits));
    check("amp_never_zero", 32'(amp_bad), 32'd0);

    finish_now();
  end

endmodule
